rom_loader: RTL
===============

Name: rom_loader

Overview:
- Boot-time initiator for the instruction-ROM wrapper interface (addr/ce/op/wr_data in, data out).
- Takes a byte stream from a serial front end, packs it into 32-bit little-endian words and writes them sequentially into BaseRAM through the wrapper.
- Holds the CPU off the wrapper port until loading completes, then releases it.

Parameters:
- ADDR_W, 32, wrapper address width (matches `InstAddrBus`)
- DATA_W, 32, wrapper data width (matches `InstBus`); fixed at 4 bytes per word
- BASE_ADDR, 32'h0000_0000, byte address of the first word written
- CNT_W, 20, width of the word-count field (max 2^20-1 words)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-low reset
- start_i  in  1  one-cycle request to begin a load; honoured only in IDLE
- len_i  in  CNT_W  number of 32-bit words to load, sampled with start_i
- byte_i  in  8  incoming byte
- byte_valid_i  in  1  byte_i valid
- byte_ready_o  out  1  loader accepts byte this cycle; a byte transfers when valid & ready
- rom_addr_o  out  ADDR_W  to wrapper addr_i
- rom_ce_o  out  1  to wrapper ce_i, active high
- rom_op_o  out  1  to wrapper op_i (`ROM_OP_WRITE` / `ROM_OP_READ`)
- rom_wr_data_o  out  DATA_W  to wrapper wr_data_i
- rom_data_i  in  DATA_W  from wrapper data_o
- busy_o  out  1  high from accepted start through DONE
- done_o  out  1  one-cycle pulse when load finishes
- error_o  out  1  sticky readback mismatch flag (see Optional Feature)
- cpu_hold_o  out  1  high while the loader owns the wrapper port

Behaviour:
- Reset (rst==0 at a clock edge): state IDLE. rom_ce_o=0, rom_op_o=`ROM_OP_READ`, rom_addr_o=0, rom_wr_data_o=0, byte_ready_o=0, busy_o=0, done_o=0, error_o=0, cpu_hold_o=0. Byte counter, word counter and shift register are cleared. Reset mid-load aborts immediately. Partially written RAM contents are not restored.
- IDLE:
  - start_i with len_i!=0: latch len_i, set addr=BASE_ADDR, clear error_o, set busy_o=1 and cpu_hold_o=1, go to COLLECT.
  - start_i with len_i==0: go to DONE. No RAM access.
- COLLECT:
  - byte_ready_o=1 and rom_ce_o=0.
  - Each transferred byte k (0..3) lands in word bits [8k+7:8k].
  - When the 4th byte transfers, the assembled word is registered into rom_wr_data_o and the state moves to WRITE.
- WRITE (exactly 1 cycle): rom_ce_o=1, rom_op_o=`ROM_OP_WRITE`, rom_addr_o=addr, byte_ready_o=0. Next state is VERIFY_RD if the feature is enabled, otherwise ADVANCE.
- ADVANCE (combinational decision at the end of the WRITE or VERIFY_CHK cycle): addr+=4, remaining-=1.
  - remaining reaches 0: go to DONE.
  - Otherwise: go to COLLECT.
  - addr wraps modulo 2^ADDR_W.
- DONE (1 cycle): done_o=1. busy_o and cpu_hold_o drop on the next edge, return to IDLE. error_o holds its value.
- start_i outside IDLE is ignored.
- byte_valid_i outside COLLECT is back-pressured and the byte is not consumed.
- Throughput: 4 byte cycles + 1 write cycle per word minimum.
- Latency without verify: 4th byte accepted at edge t, write cycle t..t+1, done_o high in cycle t+1..t+2.
- Wrapper timing: a write takes effect in its single ce=1 cycle. Read data on rom_data_i is valid in the cycle after the read address/op is presented.

Optional Feature:
- Macro: ROM_LOADER_VERIFY_EN.
- Defined:
  - After each WRITE the loader inserts VERIFY_RD: ce=1, op=`ROM_OP_READ`, same addr, wr_data held.
  - It then inserts VERIFY_CHK: ce=0, compare rom_data_i against the written word.
  - A mismatch sets error_o (sticky until next accepted start). The load continues.
  - Per-word cost is +2 cycles.
- Undefined: no readback states, error_o is tied 0, WRITE goes directly to ADVANCE.

Test Plan:
- Load of 4 words, bytes 00..0F streamed back-to-back:
  - RAM holds 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C at addresses 0x0, 0x4, 0x8, 0xC.
  - Exactly 4 write cycles occur.
  - One done_o pulse; error_o=0.
- start_i with len_i=0 -> done_o pulses on the next cycle, rom_ce_o never asserted, busy_o high for exactly one cycle.
- byte_valid_i gapped (1 valid every 3 cycles), len_i=2 -> same packed words as the back-to-back case, no byte lost or duplicated.
- byte_ready_o observed low during WRITE.
- Reset asserted in COLLECT after 2 bytes of word 1 -> all outputs at reset values next edge, and a new start re-packs from byte 0 at BASE_ADDR.
- start_i pulsed again mid-load -> ignored; word count and address continue unchanged.
- With ROM_LOADER_VERIFY_EN, load 1 word 0xDEADBEEF:
  - Correct SRAM model: error_o stays 0, done_o arrives 2 cycles later than without the macro.
  - SRAM model forced to return 0xDEADBEEE: error_o=1 after VERIFY_CHK and stays 1 through DONE.

Source files
------------

// File: rtl/rom_loader.sv
// Boot loader: packs a byte stream into 32-bit little-endian words and writes them to the instruction RAM wrapper.
// Latency: 4 byte cycles + 1 write cycle per word (+2 readback cycles with ROM_LOADER_VERIFY_EN); done 1 cycle after the last write (or check).
// Backpressure: byte_ready_o is high only while collecting bytes; bytes offered in any other state stay with the sender.

`ifndef ROM_OP_READ
`define ROM_OP_READ 1'b0
`endif
`ifndef ROM_OP_WRITE
`define ROM_OP_WRITE 1'b1
`endif

module rom_loader #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
    parameter int                CNT_W     = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  len_i,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic              rom_ce_o,
    output logic              rom_op_o,
    output logic [DATA_W-1:0] rom_wr_data_o,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic              cpu_hold_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_VERIFY_RD,
        S_VERIFY_CHK,
        S_DONE
    } state_t;

    state_t             state_q, state_n;
    logic [ADDR_W-1:0]  addr_q;
    logic [CNT_W-1:0]   remaining_q;
    logic [1:0]         byte_cnt_q;
    logic [23:0]        shift_q;
    logic [DATA_W-1:0]  wr_data_q;

    logic byte_xfer;
    logic last_word;
    logic advance;

    assign byte_xfer = byte_valid_i && byte_ready_o;
    assign last_word = (remaining_q == CNT_W'(1));

    // A word is finished once its write (and readback check, if enabled) cycle ends.
`ifdef ROM_LOADER_VERIFY_EN
    assign advance = (state_q == S_VERIFY_CHK);
`else
    assign advance = (state_q == S_WRITE);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state logic and wrapper/handshake outputs decoded from the state.
    always_comb begin
        state_n      = state_q;
        byte_ready_o = 1'b0;
        rom_ce_o     = 1'b0;
        rom_op_o     = `ROM_OP_READ;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_n = (len_i == '0) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                byte_ready_o = 1'b1;
                if (byte_valid_i && byte_cnt_q == 2'd3) begin
                    state_n = S_WRITE;
                end
            end
            S_WRITE: begin
                rom_ce_o = 1'b1;
                rom_op_o = `ROM_OP_WRITE;
`ifdef ROM_LOADER_VERIFY_EN
                state_n  = S_VERIFY_RD;
`else
                state_n  = last_word ? S_DONE : S_COLLECT;
`endif
            end
`ifdef ROM_LOADER_VERIFY_EN
            S_VERIFY_RD: begin
                rom_ce_o = 1'b1;
                rom_op_o = `ROM_OP_READ;
                state_n  = S_VERIFY_CHK;
            end
            S_VERIFY_CHK: begin
                state_n = last_word ? S_DONE : S_COLLECT;
            end
`endif
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Datapath: load setup, little-endian byte packing, address/count advance.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q      <= '0;
            remaining_q <= '0;
            byte_cnt_q  <= '0;
            shift_q     <= '0;
            wr_data_q   <= '0;
        end else begin
            if (state_q == S_IDLE && start_i) begin
                byte_cnt_q <= '0;
                shift_q    <= '0;
                if (len_i != '0) begin
                    remaining_q <= len_i;
                    addr_q      <= BASE_ADDR;
                end
            end
            if (state_q == S_COLLECT && byte_xfer) begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
                case (byte_cnt_q)
                    2'd0:    shift_q[7:0]   <= byte_i;
                    2'd1:    shift_q[15:8]  <= byte_i;
                    2'd2:    shift_q[23:16] <= byte_i;
                    default: wr_data_q      <= {byte_i, shift_q};
                endcase
            end
            if (advance) begin
                addr_q      <= addr_q + ADDR_W'(4);
                remaining_q <= remaining_q - CNT_W'(1);
            end
        end
    end

`ifdef ROM_LOADER_VERIFY_EN
    logic error_q;

    // Sticky readback mismatch flag, cleared when a non-empty load is accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            error_q <= 1'b0;
        end else if (state_q == S_IDLE && start_i && len_i != '0) begin
            error_q <= 1'b0;
        end else if (state_q == S_VERIFY_CHK && rom_data_i != wr_data_q) begin
            error_q <= 1'b1;
        end
    end

    assign error_o = error_q;
`else
    logic unused_rom_data;
    assign unused_rom_data = ^rom_data_i;
    assign error_o         = 1'b0;
`endif

    assign rom_addr_o    = addr_q;
    assign rom_wr_data_o = wr_data_q;
    assign busy_o        = (state_q != S_IDLE);
    assign cpu_hold_o    = (state_q != S_IDLE);
    assign done_o        = (state_q == S_DONE);

endmodule
